// File: rtl/hadd_carry_resolver.sv
// Serial carry resolver for the half-adder datapath.
// Takes one generate/propagate pair per beat, LSB first, ripples the carry
// bit by bit and presents the WIDTH-bit sum plus carry-out through a
// valid/ready handshake. in_last is checked against the fixed frame length.
module hadd_carry_resolver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_gen,
  input  logic             in_prop,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_len_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx;
  logic             carry;
  logic             err;

  logic             beat;        // beat accepted this cycle
  logic             frame_start; // accepted beat is bit 0 of a new frame
  logic             last_beat;   // accepted beat is bit WIDTH-1

  logic             carry_in;
  logic             sum_bit;
  logic             carry_nx;
  logic             err_nx;
  logic [WIDTH-1:0] sum_nx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    busy        = 1'b0;
    beat        = 1'b0;
    frame_start = 1'b0;
    last_beat   = 1'b0;
    case (state)
      IDLE: begin
        beat = in_valid;
        if (beat) begin
          frame_start = 1'b1;
          state_nx    = COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        beat = in_valid;
        if (beat && idx == LAST_IDX) begin
          last_beat = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        beat      = in_valid & out_ready;
        if (out_ready) begin
          // Zero-bubble: a beat arriving with the handshake opens the next frame
          frame_start = beat;
          state_nx    = beat ? COLLECT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-bit carry resolution; a new frame always starts from carry 0 and a clean error flag
  always_comb begin
    carry_in = frame_start ? 1'b0 : carry;
    sum_bit  = in_prop ^ carry_in;
    carry_nx = in_gen | (in_prop & carry_in);
    err_nx   = (frame_start ? 1'b0 : err)
             | (in_last  & (idx != LAST_IDX))
             | (~in_last & (idx == LAST_IDX));
    sum_nx      = frame_start ? '0 : out_sum;
    sum_nx[idx] = sum_bit;
  end

  // Datapath registers: sum assembly, carry, bit index and frame results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry       <= 1'b0;
      idx         <= '0;
      err         <= 1'b0;
      out_sum     <= '0;
      out_cout    <= 1'b0;
      out_len_err <= 1'b0;
    end else if (beat) begin
      carry   <= carry_nx;
      err     <= err_nx;
      out_sum <= sum_nx;
      if (last_beat) begin
        idx         <= '0;
        out_cout    <= carry_nx;
        out_len_err <= err_nx;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hadd_carry_resolver.sv
// Directed bench for hadd_carry_resolver (WIDTH=8).
module tb_hadd_carry_resolver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_gen;
  logic             in_prop;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_len_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;

  hadd_carry_resolver #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_gen      (in_gen),
    .in_prop     (in_prop),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_cout    (out_cout),
    .out_len_err (out_len_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat at a negedge and return at the negedge after it is accepted.
  task automatic send_beat(input logic g, input logic p, input logic l, input logic gap);
    int tries;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_gen   = g;
    in_prop  = p;
    in_last  = l;
    tries    = 0;
    #1;
    if (!in_ready) stalls++;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (tries >= 50) chk("beat_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  // Send nbeats of x+y as gen/prop LSB first; in_last asserted on beat lastpos.
  task automatic send_frame(input logic [7:0] x, input logic [7:0] y,
                            input int lastpos, input int nbeats, input logic gaps);
    for (int i = 0; i < nbeats; i++)
      send_beat(x[i] & y[i], x[i] ^ y[i], (i == lastpos), gaps && (i != 0));
  endtask

  task automatic chk_result(input string tag, input logic [7:0] s,
                            input logic c, input logic e);
    chk({tag, "_valid"}, 64'(out_valid),   64'd1);
    chk({tag, "_sum"},   64'(out_sum),     64'(s));
    chk({tag, "_cout"},  64'(out_cout),    64'(c));
    chk({tag, "_err"},   64'(out_len_err), 64'(e));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_gen    = 1'b0;
    in_prop   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid),   64'd0);
    chk("rst_sum",   64'(out_sum),     64'd0);
    chk("rst_cout",  64'(out_cout),    64'd0);
    chk("rst_err",   64'(out_len_err), 64'd0);
    chk("rst_busy",  64'(busy),        64'd0);
    chk("rst_ready", 64'(in_ready),    64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x5A + 0x3C = 0x96, consumer not ready
    send_frame(8'h5A, 8'h3C, 7, 3, 1'b0);
    chk("f1_busy", 64'(busy), 64'd1);
    chk("f1_novalid", 64'(out_valid), 64'd0);
    send_frame(8'h5A >> 3, 8'h3C >> 3, 4, 5, 1'b0);
    in_valid = 1'b0;
    chk_result("f1", 8'h96, 1'b0, 1'b0);
    chk("f1_busy_done", 64'(busy), 64'd0);

    // Backpressure for 5 cycles while the next frame waits at the input
    fork
      send_frame(8'hFF, 8'h01, 7, 8, 1'b0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_ready", 64'(in_ready),  64'd0);
          chk("bp_valid", 64'(out_valid), 64'd1);
          chk("bp_sum",   64'(out_sum),   64'h96);
          chk("bp_cout",  64'(out_cout),  64'd0);
        end
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    chk_result("ff01", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("ff01_drain", 64'(out_valid), 64'd0);

    // Back-to-back frames with the consumer always ready
    stalls = 0;
    send_frame(8'h01, 8'h01, 7, 8, 1'b0);
    chk_result("b2b_a", 8'h02, 1'b0, 1'b0);
    send_frame(8'h80, 8'h80, 7, 8, 1'b0);
    chk_result("b2b_b", 8'h00, 1'b1, 1'b0);
    chk("b2b_stalls", 64'(stalls), 64'd0);

    // in_last early on beat 3, then a clean frame
    send_frame(8'h12, 8'h34, 3, 8, 1'b0);
    chk_result("early_last", 8'h46, 1'b0, 1'b1);
    send_frame(8'h03, 8'h05, 7, 8, 1'b0);
    chk_result("clean_after", 8'h08, 1'b0, 1'b0);

    // Idle cycles inside a frame: carry and index must hold
    send_frame(8'hA5, 8'h5B, 7, 8, 1'b1);
    in_valid = 1'b0;
    chk_result("gaps", 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    // Reset mid-frame after beat 4
    send_frame(8'hFF, 8'hFF, 7, 5, 1'b0);
    in_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_valid", 64'(out_valid),   64'd0);
    chk("mr_sum",   64'(out_sum),     64'd0);
    chk("mr_cout",  64'(out_cout),    64'd0);
    chk("mr_err",   64'(out_len_err), 64'd0);
    chk("mr_busy",  64'(busy),        64'd0);
    send_frame(8'h0F, 8'h01, 7, 8, 1'b0);
    in_valid = 1'b0;
    chk_result("post_rst", 8'h10, 1'b0, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
